// File: rtl/comp_evt_sched_if.sv
// comp_evt_sched_if: comparator-event and CPU register/interrupt bundle for comp_evt_sched
interface comp_evt_sched_if #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int QW  = 4
);
    logic [NCH-1:0] ch_update;
    logic [NCH-1:0] ch_low;
    logic [NCH-1:0] ch_high;
    logic [QW-1:0]  reg_qual;
    logic [NCH-1:0] reg_ilen;
    logic [NCH-1:0] reg_ihen;
    logic [NCH-1:0] reg_lclrflg;
    logic [NCH-1:0] reg_hclrflg;
    logic [NCH-1:0] flg_clr_low;
    logic [NCH-1:0] flg_clr_high;
    logic [NCH-1:0] flg_low;
    logic [NCH-1:0] flg_high;
    logic           irq;
    logic [CW-1:0]  irq_ch;
    logic [1:0]     irq_src;
    logic           irq_ack;

    modport master (
        output ch_update, ch_low, ch_high, reg_qual, reg_ilen, reg_ihen,
               reg_lclrflg, reg_hclrflg, flg_clr_low, flg_clr_high, irq_ack,
        input  flg_low, flg_high, irq, irq_ch, irq_src
    );

    modport slave (
        input  ch_update, ch_low, ch_high, reg_qual, reg_ilen, reg_ihen,
               reg_lclrflg, reg_hclrflg, flg_clr_low, flg_clr_high, irq_ack,
        output flg_low, flg_high, irq, irq_ch, irq_src
    );
endinterface

// File: rtl/comp_evt_sched.sv
// comp_evt_sched: qualifies comparator threshold events into sticky flags and round-robin interrupts
module comp_evt_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int QW  = 4
) (
    input logic             SYSCLK,
    input logic             SYSRSTn,
    comp_evt_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEL, ASRT, GAP} state_t;

    state_t         r_state, w_next;
    logic [QW-1:0]  r_qcl [NCH];
    logic [QW-1:0]  r_qch [NCH];
    logic [NCH-1:0] r_flg_l, r_flg_h, r_pend_l, r_pend_h;
    logic [NCH-1:0] w_set_l, w_set_h, w_pl, w_ph, w_any, w_ackl, w_ackh;
    logic [CW-1:0]  r_rr, r_irq_ch, w_sel;
    logic [1:0]     r_irq_src;
    logic [QW:0]    w_thr;
    logic           w_found, w_latch, w_ack;

    // a qualification setting of zero behaves like one
    assign w_thr = (bus.reg_qual == '0) ? (QW+1)'(1) : {1'b0, bus.reg_qual};
    // pending bits are only visible to the scheduler while their enable is set
    assign w_pl  = r_pend_l & bus.reg_ilen;
    assign w_ph  = r_pend_h & bus.reg_ihen;
    assign w_any = w_pl | w_ph;
    assign w_ackl = (w_ack && r_irq_src[0]) ? (NCH'(1) << r_irq_ch) : '0;
    assign w_ackh = (w_ack && r_irq_src[1]) ? (NCH'(1) << r_irq_ch) : '0;

    // set event: a true update that completes the required run of qualifying updates
    always_comb begin
        w_set_l = '0;
        w_set_h = '0;
        for (int k = 0; k < NCH; k++) begin
            w_set_l[k] = bus.ch_update[k] & bus.ch_low[k]  & (({1'b0, r_qcl[k]} + (QW+1)'(1)) >= w_thr);
            w_set_h[k] = bus.ch_update[k] & bus.ch_high[k] & (({1'b0, r_qch[k]} + (QW+1)'(1)) >= w_thr);
        end
    end

    // first requesting channel at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr;
        for (int k = 0; k < NCH; k++) begin
            if (!w_found && w_any[CW'(r_rr + CW'(k))]) begin
                w_found = 1'b1;
                w_sel   = CW'(r_rr + CW'(k));
            end
        end
    end

    // per-channel qualification counters, sticky flags and pending bits
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTn) begin
            r_flg_l  <= '0;
            r_flg_h  <= '0;
            r_pend_l <= '0;
            r_pend_h <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_qcl[k] <= '0;
                r_qch[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.ch_update[k]) begin
                    r_qcl[k] <= bus.ch_low[k]  ? ((&r_qcl[k]) ? r_qcl[k] : r_qcl[k] + QW'(1)) : '0;
                    r_qch[k] <= bus.ch_high[k] ? ((&r_qch[k]) ? r_qch[k] : r_qch[k] + QW'(1)) : '0;
                end
                r_flg_l[k]  <= w_set_l[k] | (r_flg_l[k] & ~(bus.flg_clr_low[k] |
                               (bus.reg_lclrflg[k] & bus.ch_update[k] & ~bus.ch_low[k])));
                r_flg_h[k]  <= w_set_h[k] | (r_flg_h[k] & ~(bus.flg_clr_high[k] |
                               (bus.reg_hclrflg[k] & bus.ch_update[k] & ~bus.ch_high[k])));
                r_pend_l[k] <= bus.reg_ilen[k] & (w_set_l[k] | (r_pend_l[k] & ~w_ackl[k]));
                r_pend_h[k] <= bus.reg_ihen[k] & (w_set_h[k] | (r_pend_h[k] & ~w_ackh[k]));
            end
        end
    end

    // scheduler state, serviced channel and round-robin pointer
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTn) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_irq_ch  <= '0;
            r_irq_src <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_irq_ch  <= w_sel;
                r_irq_src <= {w_ph[w_sel], w_pl[w_sel]};
            end
            if (w_ack) r_rr <= r_irq_ch + CW'(1);
        end
    end

    // scheduler next state and latch/acknowledge strobes
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            IDLE: w_next = (|w_any) ? SEL : IDLE;
            SEL: begin
                w_latch = w_found;
                w_next  = w_found ? ASRT : IDLE;
            end
            ASRT: begin
                w_ack  = bus.irq_ack;
                w_next = bus.irq_ack ? GAP : ASRT;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.flg_low  = r_flg_l;
    assign bus.flg_high = r_flg_h;
    assign bus.irq      = (r_state == ASRT);
    assign bus.irq_ch   = r_irq_ch;
    assign bus.irq_src  = r_irq_src;
endmodule
